dram_timing_model: RTL and testbench

- Word-addressed DRAM endpoint directly downstream of the SoC's DMA-facing DRAM port (dramAddress/dramWriteData/dramWriteEnable/dramReadEnable in, dramReadData/dramValid out).
- Services one word request at a time, with a fixed row-miss latency and a shorter row-hit latency.
- Used in simulation and on FPGA so that d2s/s2d transfers see realistic, non-zero memory latency.

---
 rtl/dram_pkg.sv | 13 +
 rtl/dram_array.sv | 24 ++
 rtl/dram_timing_model.sv | 136 +++++++++++++
 tb/tb_dram_timing_model.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/dram_pkg.sv
// Shared DRAM model types and default timing constants, reusable by the DMA
// controller bench alongside the model itself.
package dram_pkg;

   typedef enum logic [1:0] {IDLE, WAIT, RESP} dram_state_t;

   localparam int WORD_BYTES        = 4;
   localparam int DEF_MEM_WORDS     = 16384;
   localparam int DEF_MISS_LATENCY  = 6;
   localparam int DEF_HIT_LATENCY   = 2;
   localparam int DEF_ROW_SHIFT     = 10;

endpackage

// File: rtl/dram_array.sv
// Synchronous single-port word RAM backing the DRAM model; rdata only changes
// on a read access so it holds the last read word between reads.
module dram_array #(
  parameter int    WORDS     = 16384,
  parameter string INIT_FILE = ""
) (
  input  logic                     clk,
  input  logic                     en,
  input  logic                     we,
  input  logic [$clog2(WORDS)-1:0] addr,
  input  logic [31:0]              wdata,
  output logic [31:0]              rdata
);

  logic [31:0] mem [WORDS];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) mem[addr] <= wdata;
      else    rdata     <= mem[addr];
    end
  end

endmodule

// File: rtl/dram_timing_model.sv
// Word-addressed DRAM endpoint with an open-row model: row hits complete after
// HIT_LATENCY cycles, misses after MISS_LATENCY, one request at a time.
module dram_timing_model
   import dram_pkg::*;
#(
   parameter int    MEM_WORDS    = DEF_MEM_WORDS,
   parameter int    MISS_LATENCY = DEF_MISS_LATENCY,
   parameter int    HIT_LATENCY  = DEF_HIT_LATENCY,
   parameter int    ROW_SHIFT    = DEF_ROW_SHIFT,
   parameter string INIT_FILE    = "dramdata.mem"
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] dramAddress,
   input  logic [31:0] dramWriteData,
   input  logic        dramWriteEnable,
   input  logic        dramReadEnable,
   output logic [31:0] dramReadData,
   output logic        dramValid,
   output logic        busy,
   output logic        protocolError
);

   localparam int AW    = $clog2(MEM_WORDS);
   localparam int CNT_W = $clog2(MISS_LATENCY) + 1;
   localparam int ROW_W = 32 - ROW_SHIFT;

   dram_state_t      state;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] lat_sel;
   logic [AW-1:0]    lat_idx;
   logic [31:0]      lat_data;
   logic             lat_we;
   logic [ROW_W-1:0] lat_row;
   logic [ROW_W-1:0] open_row;
   logic             open_vld;
   logic             rd_seen;

   logic             req;
   logic             row_hit;
   logic             fast_go;
   logic             wait_go;
   logic             go;
   logic             ram_we;
   logic [AW-1:0]    ram_idx;
   logic [31:0]      ram_wdata;
   logic [31:0]      ram_rdata;
   logic [ROW_W-1:0] go_row;
   logic             unused_addr_bits;

   assign req     = dramWriteEnable | dramReadEnable;
   assign row_hit = open_vld && (open_row == dramAddress[31:ROW_SHIFT]);
   assign lat_sel = row_hit ? CNT_W'(HIT_LATENCY) : CNT_W'(MISS_LATENCY);
   assign fast_go = (state == IDLE) && req && (lat_sel == CNT_W'(1));
   assign wait_go = (state == WAIT) && (cnt == '0);

   // The array is touched only on the edge that enters RESP; a single-cycle
   // latency bypasses the latch and uses the live request directly.
   assign go        = (fast_go | wait_go) & reset;
   assign ram_idx   = fast_go ? dramAddress[AW+1:2] : lat_idx;
   assign ram_wdata = fast_go ? dramWriteData       : lat_data;
   assign ram_we    = fast_go ? dramWriteEnable     : lat_we;
   assign go_row    = fast_go ? dramAddress[31:ROW_SHIFT] : lat_row;

   assign unused_addr_bits = ^dramAddress[1:0];

   dram_array #(
      .WORDS     (MEM_WORDS),
      .INIT_FILE (INIT_FILE)
   ) u_array (
      .clk   (clk),
      .en    (go),
      .we    (ram_we),
      .addr  (ram_idx),
      .wdata (ram_wdata),
      .rdata (ram_rdata)
   );

   // Array read register is not reset, so the output stays zero until a read lands.
   assign dramReadData = rd_seen ? ram_rdata : '0;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state         <= IDLE;
         cnt           <= '0;
         busy          <= 1'b0;
         dramValid     <= 1'b0;
         protocolError <= 1'b0;
         open_vld      <= 1'b0;
         rd_seen       <= 1'b0;
      end else begin
         dramValid <= 1'b0;
         case (state)
            IDLE: begin
               if (req) begin
                  if (dramWriteEnable && dramReadEnable) protocolError <= 1'b1;
                  if (fast_go) begin
                     state     <= RESP;
                     dramValid <= 1'b1;
                     open_vld  <= 1'b1;
                     if (!dramWriteEnable) rd_seen <= 1'b1;
                  end else begin
                     state <= WAIT;
                     busy  <= 1'b1;
                     cnt   <= lat_sel - CNT_W'(2);
                  end
               end
            end
            WAIT: begin
               if (cnt == '0) begin
                  state     <= RESP;
                  busy      <= 1'b0;
                  dramValid <= 1'b1;
                  open_vld  <= 1'b1;
                  if (!lat_we) rd_seen <= 1'b1;
               end else begin
                  cnt <= cnt - CNT_W'(1);
               end
            end
            RESP:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if ((state == IDLE) && req) begin
         lat_idx  <= dramAddress[AW+1:2];
         lat_data <= dramWriteData;
         lat_we   <= dramWriteEnable;
         lat_row  <= dramAddress[31:ROW_SHIFT];
      end
      if (go) open_row <= go_row;
   end

endmodule

// File: tb/tb_dram_timing_model.sv
// Directed and randomized bench for dram_timing_model against an open-row,
// fixed-latency reference model of the memory.
module tb_dram_timing_model;

   localparam int MEM_WORDS = 16384;
   localparam int MISS      = 6;
   localparam int HIT       = 2;
   localparam int ROW_SHIFT = 10;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [31:0] dramAddress = '0;
   logic [31:0] dramWriteData = '0;
   logic        dramWriteEnable = 1'b0;
   logic        dramReadEnable = 1'b0;
   logic [31:0] dramReadData;
   logic        dramValid;
   logic        busy;
   logic        protocolError;

   int checks = 0;
   int errors = 0;

   logic [31:0] m_mem [int];
   logic [31:0] m_open_row = '0;
   bit          m_open_vld = 1'b0;
   bit          m_perr = 1'b0;
   logic [31:0] m_last_rd = '0;
   logic [31:0] waddrs [$];

   dram_timing_model #(
      .MEM_WORDS    (MEM_WORDS),
      .MISS_LATENCY (MISS),
      .HIT_LATENCY  (HIT),
      .ROW_SHIFT    (ROW_SHIFT),
      .INIT_FILE    ("")
   ) dut (
      .clk             (clk),
      .reset           (reset),
      .dramAddress     (dramAddress),
      .dramWriteData   (dramWriteData),
      .dramWriteEnable (dramWriteEnable),
      .dramReadEnable  (dramReadEnable),
      .dramReadData    (dramReadData),
      .dramValid       (dramValid),
      .busy            (busy),
      .protocolError   (protocolError)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // One complete transaction, timed against the reference model's latency.
   task automatic do_req(input bit w, input bit r, input logic [31:0] a,
                         input logic [31:0] d, input string tag);
      int          exp_lat;
      int          lat;
      int          idx;
      bit          seen;
      idx     = int'((a >> 2) % MEM_WORDS);
      exp_lat = (m_open_vld && m_open_row == (a >> ROW_SHIFT)) ? HIT : MISS;
      @(negedge clk);
      dramAddress     = a;
      dramWriteData   = d;
      dramWriteEnable = w;
      dramReadEnable  = r;
      @(posedge clk);
      if (w && r) m_perr = 1'b1;
      #1;
      dramAddress   = $urandom;
      dramWriteData = $urandom;
      lat  = 0;
      seen = 1'b0;
      for (int n = 1; n <= MISS + 2 && !seen; n++) begin
         @(negedge clk);
         if (dramValid) begin
            seen = 1'b1;
            lat  = n;
         end else begin
            check({tag, " busy"}, {31'b0, busy}, 32'd1);
         end
      end
      check({tag, " latency"}, lat, exp_lat);
      if (w) begin
         m_mem[idx] = d;
         waddrs.push_back(a);
      end else begin
         m_last_rd = m_mem[idx];
      end
      m_open_row = a >> ROW_SHIFT;
      m_open_vld = 1'b1;
      check({tag, " busy@valid"}, {31'b0, busy}, 32'd0);
      check({tag, " rdata"}, dramReadData, m_last_rd);
      check({tag, " perr"}, {31'b0, protocolError}, {31'b0, m_perr});
      dramWriteEnable = 1'b0;
      dramReadEnable  = 1'b0;
      @(negedge clk);
      check({tag, " valid pulse"}, {31'b0, dramValid}, 32'd0);
   endtask

   initial begin
      repeat (2) @(negedge clk);
      check("reset rdata", dramReadData, 32'd0);
      check("reset valid", {31'b0, dramValid}, 32'd0);
      check("reset busy", {31'b0, busy}, 32'd0);
      check("reset perr", {31'b0, protocolError}, 32'd0);
      reset = 1'b1;

      do_req(1, 0, 32'h0000_0008, 32'h8888_8888, "pre8");
      do_req(1, 0, 32'h0000_0000, 32'h0000_AAAA, "pre0");
      do_req(1, 0, 32'h0000_0104, 32'h0BAD_0104, "pre104");
      do_req(1, 0, 32'h0000_0040, 32'h1111_0040, "pre40");
      do_req(1, 0, 32'h0000_000C, 32'hCAFE_BABE, "preC");
      do_req(1, 0, 32'h0000_0404, 32'h4040_4040, "pre404");
      do_req(1, 0, 32'h0000_0400, 32'h4000_0400, "pre400");

      do_req(0, 1, 32'h0000_000C, 32'h0, "rdC");
      do_req(0, 1, 32'h0000_0400, 32'h0, "rowswap");
      do_req(1, 0, 32'h0000_0100, 32'h1234_5678, "wr100");
      do_req(0, 1, 32'h0000_0104, 32'h0, "rd104hit");
      do_req(0, 1, 32'h0000_0100, 32'h0, "rd100");
      do_req(0, 1, 32'h0000_0400, 32'h0, "rd400a");
      do_req(0, 1, 32'h0000_0000, 32'h0, "rd0a");
      do_req(0, 1, 32'h0000_0400, 32'h0, "rd400b");
      do_req(0, 1, 32'h0000_0000, 32'h0, "rd0b");
      do_req(0, 1, 32'h0000_0400, 32'h0, "rd400c");
      do_req(0, 1, 32'h0000_0404, 32'h0, "rd404hit");

      do_req(1, 1, 32'h0000_0020, 32'hA5A5_A5A5, "both");
      do_req(0, 1, 32'h0000_0020, 32'h0, "rd20");
      check("perr sticky", {31'b0, protocolError}, 32'd1);

      // Write aborted by reset partway through its miss wait.
      do_req(0, 1, 32'h0000_0400, 32'h0, "rowswap2");
      @(negedge clk);
      dramAddress     = 32'h0000_0040;
      dramWriteData   = 32'hDEAD_BEEF;
      dramWriteEnable = 1'b1;
      @(posedge clk);
      repeat (2) begin
         @(negedge clk);
         check("abort pre valid", {31'b0, dramValid}, 32'd0);
      end
      @(negedge clk);
      reset = 1'b0;
      #1;
      check("abort busy", {31'b0, busy}, 32'd0);
      check("abort perr", {31'b0, protocolError}, 32'd0);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("abort valid", {31'b0, dramValid}, 32'd0);
      end
      dramWriteEnable = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      m_open_vld = 1'b0;
      m_perr     = 1'b0;
      m_last_rd  = '0;
      check("post reset rdata", dramReadData, 32'd0);
      do_req(0, 1, 32'h0000_0040, 32'h0, "rd40 after abort");
      do_req(0, 1, 32'h0001_0008, 32'h0, "rd alias");
      check("alias data", dramReadData, 32'h8888_8888);

      for (int t = 0; t < 40; t++) begin
         logic [31:0] a;
         if (waddrs.size() == 0 || $urandom_range(0, 1) == 0) begin
            a = ($urandom_range(0, 3) << ROW_SHIFT) | ($urandom_range(0, 255) << 2);
            do_req(1, ($urandom_range(0, 7) == 0), a, $urandom, "rnd wr");
         end else begin
            a = waddrs[$urandom_range(0, waddrs.size() - 1)];
            if ($urandom_range(0, 3) == 0) a = a + 32'h0001_0000;
            do_req(0, 1, a, 32'h0, "rnd rd");
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
